block_nonblock: RTL and testbench

- Registered 1-bit full-adder-style population counter: `out` is the 2-bit sum of the three 1-bit inputs `a`, `b` and `c`.
- Demonstrates the timing difference between blocking and non-blocking evaluation of a two-step sum. The step is intermediate `d = a + b`, then `out = d + c`.
- A parameter selects between the two timing models.
- Standalone teaching/utility block; single clock domain.

---
 rtl/block_nonblock.sv | 41 ++++
 tb/tb_block_nonblock.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/block_nonblock.sv
// Registered 3-input population counter (out = a + b + c) with selectable
// single-register or two-stage (registered a+b, then + c) timing models.
module block_nonblock #(
    parameter int unsigned PIPE_MODE = 0
) (
    input  logic       Clock,
    input  logic       Rst_n,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    output logic [1:0] out
);

    logic [1:0] r_d;
    logic [1:0] r_out;
    logic [1:0] w_ab;
    logic [1:0] w_sum_now;
    logic [1:0] w_sum_pipe;
    logic [1:0] w_next_out;

    always_comb begin
        w_ab       = {1'b0, a} + {1'b0, b};
        w_sum_now  = w_ab + {1'b0, c};
        // Two-stage model pairs the previous edge's a+b with the current c.
        w_sum_pipe = r_d + {1'b0, c};
        w_next_out = (PIPE_MODE == 0) ? w_sum_now : w_sum_pipe;
    end

    always_ff @(posedge Clock or negedge Rst_n) begin
        if (!Rst_n) begin
            r_d   <= '0;
            r_out <= '0;
        end else begin
            r_d   <= w_ab;
            r_out <= w_next_out;
        end
    end

    assign out = r_out;

endmodule

// File: tb/tb_block_nonblock.sv
// Scoreboard bench for block_nonblock: both timing models run side by side
// on shared inputs, with expectations taken from a sampled-input history.
module tb_block_nonblock;

    logic       Clock = 1'b0;
    logic       Rst_n = 1'b0;
    logic       a = 1'b0;
    logic       b = 1'b0;
    logic       c = 1'b0;
    logic [1:0] out0;
    logic [1:0] out1;

    int checks = 0;
    int errors = 0;

    logic [2:0] hist[$];
    logic [1:0] q0[$];
    logic [1:0] q1[$];

    always #5 Clock = ~Clock;

    block_nonblock #(.PIPE_MODE(0)) u_dut0 (
        .Clock(Clock), .Rst_n(Rst_n), .a(a), .b(b), .c(c), .out(out0)
    );

    block_nonblock #(.PIPE_MODE(1)) u_dut1 (
        .Clock(Clock), .Rst_n(Rst_n), .a(a), .b(b), .c(c), .out(out1)
    );

    // One rising edge: sample the inputs, push expected outputs, step to edge+1ns.
    task automatic tick();
        logic [2:0] s;
        logic [1:0] e0;
        logic [1:0] e1;
        @(posedge Clock);
        s = {a, b, c};
        if (!Rst_n) begin
            hist.delete();
            e0 = 2'd0;
            e1 = 2'd0;
        end else begin
            e0 = 2'(s[2]) + 2'(s[1]) + 2'(s[0]);
            e1 = 2'(s[0]);
            if (hist.size() > 0)
                e1 = e1 + 2'(hist[hist.size()-1][2]) + 2'(hist[hist.size()-1][1]);
            hist.push_back(s);
            if (hist.size() > 4) void'(hist.pop_front());
        end
        q0.push_back(e0);
        q1.push_back(e1);
        #1;
    endtask

    task automatic test_reset();
        logic [1:0] e;
        Rst_n = 1'b0;
        {a, b, c} = 3'b111;
        for (int i = 0; i < 200; i++) begin
            tick();
            e = q0.pop_front();
            checks++;
            if (out0 !== e) begin
                errors++;
                $display("FAIL reset_hold_m0 cyc=%0d got=%0d exp=%0d", i, out0, e);
            end
            e = q1.pop_front();
            checks++;
            if (out1 !== e) begin
                errors++;
                $display("FAIL reset_hold_m1 cyc=%0d got=%0d exp=%0d", i, out1, e);
            end
        end
        Rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            e = q0.pop_front();
            checks++;
            if (out0 !== e) begin
                errors++;
                $display("FAIL reset_run_m0 cyc=%0d got=%0d exp=%0d", i, out0, e);
            end
            e = q1.pop_front();
            checks++;
            if (out1 !== e) begin
                errors++;
                $display("FAIL reset_run_m1 cyc=%0d got=%0d exp=%0d", i, out1, e);
            end
        end
        // Assert reset midway between edges; outputs must clear before the next edge.
        #2;
        Rst_n = 1'b0;
        hist.delete();
        #1;
        checks++;
        if (out0 !== 2'd0) begin
            errors++;
            $display("FAIL async_reset_m0 got=%0d exp=0", out0);
        end
        checks++;
        if (out1 !== 2'd0) begin
            errors++;
            $display("FAIL async_reset_m1 got=%0d exp=0", out1);
        end
    endtask

    task automatic test_sweep();
        logic [1:0] e;
        logic [1:0] steady [8];
        steady = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};
        tick();
        void'(q0.pop_front());
        void'(q1.pop_front());
        Rst_n = 1'b1;
        for (int v = 0; v < 8; v++) begin
            {a, b, c} = 3'(v);
            for (int i = 0; i < 200; i++) begin
                tick();
                e = q0.pop_front();
                checks++;
                if (out0 !== e) begin
                    errors++;
                    $display("FAIL sweep_m0 in=%03b cyc=%0d got=%0d exp=%0d", 3'(v), i, out0, e);
                end
                e = q1.pop_front();
                checks++;
                if (out1 !== e) begin
                    errors++;
                    $display("FAIL sweep_m1 in=%03b cyc=%0d got=%0d exp=%0d", 3'(v), i, out1, e);
                end
                if (v == 1 && i == 0) begin
                    checks++;
                    if (out1 !== 2'd1) begin
                        errors++;
                        $display("FAIL c_latency_m1 got=%0d exp=1", out1);
                    end
                end
                if (v == 4 && i == 1) begin
                    checks++;
                    if (out1 !== 2'd1) begin
                        errors++;
                        $display("FAIL ab_latency_m1 got=%0d exp=1", out1);
                    end
                end
            end
            checks++;
            if (out0 !== steady[v]) begin
                errors++;
                $display("FAIL steady_m0 in=%03b got=%0d exp=%0d", 3'(v), out0, steady[v]);
            end
            checks++;
            if (out1 !== steady[v]) begin
                errors++;
                $display("FAIL steady_m1 in=%03b got=%0d exp=%0d", 3'(v), out1, steady[v]);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [1:0] e;
        logic [1:0] want1 [3];
        want1 = '{2'd1, 2'd3, 2'd3};
        {a, b, c} = 3'b000;
        for (int i = 0; i < 5; i++) begin
            tick();
            void'(q0.pop_front());
            void'(q1.pop_front());
        end
        {a, b, c} = 3'b111;
        for (int i = 0; i < 3; i++) begin
            tick();
            e = q1.pop_front();
            void'(q0.pop_front());
            checks++;
            if (out1 !== e) begin
                errors++;
                $display("FAIL simul_sb_m1 edge=%0d got=%0d exp=%0d", i + 1, out1, e);
            end
            checks++;
            if (out1 !== want1[i]) begin
                errors++;
                $display("FAIL simul_m1 edge=%0d got=%0d exp=%0d", i + 1, out1, want1[i]);
            end
            checks++;
            if (out0 !== 2'd3) begin
                errors++;
                $display("FAIL simul_m0 edge=%0d got=%0d exp=3", i + 1, out0);
            end
        end
    endtask

    task automatic test_midrun_reset();
        logic [1:0] e;
        logic [1:0] want0 [2];
        logic [1:0] want1 [2];
        want0 = '{2'd3, 2'd3};
        want1 = '{2'd1, 2'd3};
        {a, b, c} = 3'b111;
        Rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            e = q0.pop_front();
            checks++;
            if (out0 !== e) begin
                errors++;
                $display("FAIL midrst_hold_m0 cyc=%0d got=%0d exp=%0d", i, out0, e);
            end
            e = q1.pop_front();
            checks++;
            if (out1 !== e) begin
                errors++;
                $display("FAIL midrst_hold_m1 cyc=%0d got=%0d exp=%0d", i, out1, e);
            end
        end
        Rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            e = q0.pop_front();
            checks++;
            if (out0 !== e || out0 !== want0[i]) begin
                errors++;
                $display("FAIL midrst_rel_m0 edge=%0d got=%0d exp=%0d", i + 1, out0, want0[i]);
            end
            e = q1.pop_front();
            checks++;
            if (out1 !== e || out1 !== want1[i]) begin
                errors++;
                $display("FAIL midrst_rel_m1 edge=%0d got=%0d exp=%0d", i + 1, out1, want1[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_simultaneous();
        test_midrun_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
